// File: rtl/lsu_pkg.sv
// Shared constants, state type and decode helper for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_B    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_W    = 3'd3;
  localparam logic [2:0] LD_BU   = 3'd4;
  localparam logic [2:0] LD_HU   = 3'd5;

  localparam logic [3:0] ST_NONE = 4'b0000;
  localparam logic [3:0] ST_B    = 4'b0001;
  localparam logic [3:0] ST_H    = 4'b0011;
  localparam logic [3:0] ST_W    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Kinds 6 and 7 are not loads.
  function automatic logic is_load(input logic [2:0] ld);
    return (ld >= LD_B) && (ld <= LD_HU);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
interface lsu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [3:0]            mem_wmask;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_inst,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to load kind.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_inst)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'b0, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'b0, half_sel};
      LD_W:    data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one instruction in flight, registered memory request and write-back.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  e_regW,
  input  logic [ADDR_WIDTH-1:0] e_regAddr,
  input  logic [DATA_WIDTH-1:0] e_regData,
  input  logic [2:0]            e_load_inst,
  input  logic [3:0]            e_store_mask,
  input  logic [DATA_WIDTH-1:0] e_store_data,
  lsu_if.master                 mem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  m_regW,
  output logic [ADDR_WIDTH-1:0] m_regAddr,
  output logic [DATA_WIDTH-1:0] m_regData,
  output logic                  m_misalign
);

  lsu_state_e            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  req_valid_q, req_valid_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  out_valid_q, out_valid_d;
  logic                  regw_q, regw_d;
  logic [2:0]            load_q, load_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  m_regw_q, m_regw_d;
  logic [ADDR_WIDTH-1:0] m_regaddr_q, m_regaddr_d;
  logic [DATA_WIDTH-1:0] m_regdata_q, m_regdata_d;
  logic                  m_misalign_q, m_misalign_d;

  logic                  ld_valid, st_valid, half_acc, word_acc, misalign;
  logic [DATA_WIDTH-1:0] load_data;

  // A load on the same instruction overrides any store mask.
  assign ld_valid = is_load(e_load_inst);
  assign st_valid = !ld_valid && (e_store_mask != ST_NONE);
  assign half_acc = ld_valid ? (e_load_inst == LD_H || e_load_inst == LD_HU)
                             : (st_valid && e_store_mask == ST_H);
  assign word_acc = ld_valid ? (e_load_inst == LD_W)
                             : (st_valid && e_store_mask == ST_W);
  assign misalign = (half_acc && e_regData[0]) || (word_acc && e_regData[1:0] != 2'b00);

  lsu_load_align u_load_align (
    .rdata     (mem.mem_rdata),
    .addr_lo   (addr_lo_q),
    .load_inst (load_q),
    .data      (load_data)
  );

  // Next-state and next-output decode for the IDLE/REQ/WAIT/DONE sequence.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    req_valid_d  = req_valid_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    out_valid_d  = out_valid_q;
    regw_d       = regw_q;
    load_d       = load_q;
    addr_lo_d    = addr_lo_q;
    m_regw_d     = m_regw_q;
    m_regaddr_d  = m_regaddr_q;
    m_regdata_d  = m_regdata_q;
    m_misalign_d = m_misalign_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_ready_d   = 1'b0;
          regw_d       = e_regW;
          load_d       = ld_valid ? e_load_inst : LD_NONE;
          addr_lo_d    = e_regData[1:0];
          m_regaddr_d  = e_regAddr;
          m_misalign_d = 1'b0;
          if (misalign) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            m_misalign_d = 1'b1;
            m_regw_d     = 1'b0;
            m_regdata_d  = '0;
          end else if (ld_valid || st_valid) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            addr_d      = {e_regData[DATA_WIDTH-1:2], 2'b00};
            wen_d       = st_valid;
            wmask_d     = st_valid ? (e_store_mask << e_regData[1:0]) : 4'b0000;
            wdata_d     = st_valid ? (e_store_data << {e_regData[1:0], 3'b000}) : '0;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            m_regw_d    = e_regW;
            m_regdata_d = e_regData;
          end
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_rsp_valid) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (load_q != LD_NONE) begin
            m_regw_d    = regw_q;
            m_regdata_d = load_data;
          end else begin
            m_regw_d    = 1'b0;
            m_regdata_d = '0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      req_valid_q  <= 1'b0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wmask_q      <= 4'b0000;
      wdata_q      <= '0;
      out_valid_q  <= 1'b0;
      regw_q       <= 1'b0;
      load_q       <= LD_NONE;
      addr_lo_q    <= 2'b00;
      m_regw_q     <= 1'b0;
      m_regaddr_q  <= '0;
      m_regdata_q  <= '0;
      m_misalign_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      req_valid_q  <= req_valid_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wmask_q      <= wmask_d;
      wdata_q      <= wdata_d;
      out_valid_q  <= out_valid_d;
      regw_q       <= regw_d;
      load_q       <= load_d;
      addr_lo_q    <= addr_lo_d;
      m_regw_q     <= m_regw_d;
      m_regaddr_q  <= m_regaddr_d;
      m_regdata_q  <= m_regdata_d;
      m_misalign_q <= m_misalign_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wen       = wen_q;
  assign mem.mem_wmask     = wmask_q;
  assign mem.mem_wdata     = wdata_q;
  assign out_valid         = out_valid_q;
  assign m_regW            = m_regw_q;
  assign m_regAddr         = m_regaddr_q;
  assign m_regData         = m_regdata_q;
  assign m_misalign        = m_misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit with an inline zero/multi-wait memory model.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, e_regW;
  logic [4:0]  e_regAddr;
  logic [31:0] e_regData, e_store_data;
  logic [2:0]  e_load_inst;
  logic [3:0]  e_store_mask;
  logic        out_valid, out_ready, m_regW, m_misalign;
  logic [4:0]  m_regAddr;
  logic [31:0] m_regData;

  int vectors = 0;
  int errors  = 0;
  int req_hs  = 0;
  int out_hs  = 0;
  int reqv_cyc = 0;

  always #5 clk = ~clk;

  lsu_if #(.DATA_WIDTH(32)) mif ();

  lsu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .e_regW       (e_regW),
    .e_regAddr    (e_regAddr),
    .e_regData    (e_regData),
    .e_load_inst  (e_load_inst),
    .e_store_mask (e_store_mask),
    .e_store_data (e_store_data),
    .mem          (mif),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .m_regW       (m_regW),
    .m_regAddr    (m_regAddr),
    .m_regData    (m_regData),
    .m_misalign   (m_misalign)
  );

  // Handshake / activity counters.
  always @(posedge clk) begin
    if (mif.mem_req_valid && mif.mem_req_ready) req_hs++;
    if (mif.mem_req_valid) reqv_cyc++;
    if (out_valid && out_ready) out_hs++;
  end

  task automatic send(input logic [2:0] ld, input logic [3:0] msk, input logic [31:0] a,
                      input logic [31:0] sd, input logic w, input logic [4:0] ra);
    in_valid = 1'b1; e_load_inst = ld; e_store_mask = msk; e_regData = a;
    e_store_data = sd; e_regW = w; e_regAddr = ra;
    @(posedge clk); #1;
    in_valid = 1'b0; e_load_inst = LD_NONE; e_store_mask = ST_NONE;
    e_regData = 32'h0; e_store_data = 32'h0; e_regW = 1'b0; e_regAddr = 5'd0;
  endtask

  task automatic mem_zero_wait(input logic [31:0] rd);
    mif.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b1; mif.mem_rdata = rd;
    @(posedge clk); #1;
    mif.mem_rsp_valid = 1'b0; mif.mem_rdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    vectors++; if (mif.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", mif.mem_req_valid); end
    vectors++; if ({mif.mem_addr, mif.mem_wdata, mif.mem_wmask, mif.mem_wen} !== 69'h0) begin errors++; $display("FAIL rst_mem_fields: got %h %h %b %b want zeros", mif.mem_addr, mif.mem_wdata, mif.mem_wmask, mif.mem_wen); end
    vectors++; if ({m_regW, m_regAddr, m_regData, m_misalign} !== 39'h0) begin errors++; $display("FAIL rst_m_fields: got %b %h %h %b want zeros", m_regW, m_regAddr, m_regData, m_misalign); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lb();
    send(LD_B, ST_NONE, 32'h8000_0003, 32'h0, 1'b1, 5'd7);
    vectors++; if (mif.mem_req_valid !== 1'b1) begin errors++; $display("FAIL lb_req_valid: got %b want 1", mif.mem_req_valid); end
    vectors++; if (mif.mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL lb_addr: got %h want 80000000", mif.mem_addr); end
    vectors++; if (mif.mem_wen !== 1'b0) begin errors++; $display("FAIL lb_wen: got %b want 0", mif.mem_wen); end
    mem_zero_wait(32'h80FF_1234);
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lb_out_valid: got %b want 1", out_valid); end
    vectors++; if (m_regData !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", m_regData); end
    vectors++; if (m_regW !== 1'b1 || m_regAddr !== 5'd7) begin errors++; $display("FAIL lb_wb: got %b/%0d want 1/7", m_regW, m_regAddr); end
    step();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL lb_release: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_lh();
    send(LD_HU, ST_NONE, 32'h8000_0002, 32'h0, 1'b1, 5'd8);
    vectors++; if (mif.mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL lhu_addr: got %h want 80000000", mif.mem_addr); end
    mem_zero_wait(32'hBEEF_1234);
    vectors++; if (m_regData !== 32'h0000_BEEF || m_misalign !== 1'b0) begin errors++; $display("FAIL lhu_data: got %h mis=%b want 0000beef/0", m_regData, m_misalign); end
    step();
    send(LD_H, ST_NONE, 32'h8000_0002, 32'h0, 1'b1, 5'd8);
    mem_zero_wait(32'hBEEF_1234);
    vectors++; if (m_regData !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_data: got %h want ffffbeef", m_regData); end
    step();
    send(LD_BU, ST_NONE, 32'h8000_0001, 32'h0, 1'b1, 5'd9);
    mem_zero_wait(32'h1234_F678);
    vectors++; if (m_regData !== 32'h0000_00F6) begin errors++; $display("FAIL lbu_data: got %h want 000000f6", m_regData); end
    step();
  endtask

  task automatic test_sb();
    send(LD_NONE, ST_B, 32'h8000_0002, 32'h0000_00AB, 1'b1, 5'd3);
    vectors++; if (mif.mem_wmask !== 4'b0100) begin errors++; $display("FAIL sb_wmask: got %b want 0100", mif.mem_wmask); end
    vectors++; if (mif.mem_wdata !== 32'h00AB_0000) begin errors++; $display("FAIL sb_wdata: got %h want 00ab0000", mif.mem_wdata); end
    vectors++; if (mif.mem_wen !== 1'b1 || mif.mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL sb_wen_addr: got %b/%h want 1/80000000", mif.mem_wen, mif.mem_addr); end
    mem_zero_wait(32'hDEAD_BEEF);
    vectors++; if (out_valid !== 1'b1 || m_regW !== 1'b0) begin errors++; $display("FAIL sb_wb: got ov=%b w=%b want 1/0", out_valid, m_regW); end
    step();
    send(LD_NONE, ST_H, 32'h8000_0006, 32'h0000_CDEF, 1'b0, 5'd0);
    vectors++; if (mif.mem_wmask !== 4'b1100 || mif.mem_wdata !== 32'hCDEF_0000) begin errors++; $display("FAIL sh_fields: got %b/%h want 1100/cdef0000", mif.mem_wmask, mif.mem_wdata); end
    vectors++; if (mif.mem_addr !== 32'h8000_0004) begin errors++; $display("FAIL sh_addr: got %h want 80000004", mif.mem_addr); end
    mem_zero_wait(32'h0);
    step();
  endtask

  task automatic test_load_wins();
    send(LD_W, ST_W, 32'h8000_0010, 32'h5555_5555, 1'b1, 5'd4);
    vectors++; if (mif.mem_wen !== 1'b0 || mif.mem_wmask !== 4'b0000) begin errors++; $display("FAIL ldwin_wen: got %b/%b want 0/0000", mif.mem_wen, mif.mem_wmask); end
    mem_zero_wait(32'hCAFE_F00D);
    vectors++; if (m_regData !== 32'hCAFE_F00D || m_regW !== 1'b1) begin errors++; $display("FAIL ldwin_data: got %h/%b want cafef00d/1", m_regData, m_regW); end
    step();
  endtask

  task automatic test_misalign();
    reqv_cyc = 0;
    send(LD_NONE, ST_W, 32'h8000_0001, 32'h1111_2222, 1'b1, 5'd9);
    vectors++; if (out_valid !== 1'b1 || m_misalign !== 1'b1 || m_regW !== 1'b0) begin errors++; $display("FAIL sw_mis: got ov=%b mis=%b w=%b want 1/1/0", out_valid, m_misalign, m_regW); end
    step();
    send(LD_H, ST_NONE, 32'h8000_0003, 32'h0, 1'b1, 5'd10);
    vectors++; if (out_valid !== 1'b1 || m_misalign !== 1'b1) begin errors++; $display("FAIL lh_mis: got ov=%b mis=%b want 1/1", out_valid, m_misalign); end
    step();
    send(LD_W, ST_NONE, 32'h8000_0002, 32'h0, 1'b1, 5'd11);
    vectors++; if (out_valid !== 1'b1 || m_misalign !== 1'b1) begin errors++; $display("FAIL lw_mis: got ov=%b mis=%b want 1/1", out_valid, m_misalign); end
    step();
    vectors++; if (reqv_cyc !== 0) begin errors++; $display("FAIL mis_no_req: got %0d request cycles want 0", reqv_cyc); end
  endtask

  task automatic test_alu();
    reqv_cyc = 0;
    send(LD_NONE, ST_NONE, 32'h0000_1234, 32'h0, 1'b1, 5'd5);
    vectors++; if (out_valid !== 1'b1 || m_regData !== 32'h0000_1234) begin errors++; $display("FAIL alu_data: got ov=%b %h want 1/00001234", out_valid, m_regData); end
    vectors++; if (m_regW !== 1'b1 || m_regAddr !== 5'd5 || m_misalign !== 1'b0) begin errors++; $display("FAIL alu_wb: got %b/%0d/%b want 1/5/0", m_regW, m_regAddr, m_misalign); end
    step();
    vectors++; if (reqv_cyc !== 0) begin errors++; $display("FAIL alu_no_req: got %0d request cycles want 0", reqv_cyc); end
  endtask

  task automatic test_back_to_back();
    send(3'd6, ST_NONE, 32'hAAAA_0001, 32'h0, 1'b1, 5'd0);
    vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || m_regData !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_first: got ov=%b ir=%b %h want 1/0/aaaa0001", out_valid, in_ready, m_regData); end
    step();
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ir=%b ov=%b want 1/0", in_ready, out_valid); end
    send(LD_NONE, ST_NONE, 32'hBBBB_0002, 32'h0, 1'b0, 5'd31);
    vectors++; if (out_valid !== 1'b1 || m_regData !== 32'hBBBB_0002 || m_regW !== 1'b0 || m_regAddr !== 5'd31) begin errors++; $display("FAIL b2b_second: got ov=%b %h %b %0d want 1/bbbb0002/0/31", out_valid, m_regData, m_regW, m_regAddr); end
    step();
  endtask

  task automatic test_backpressure();
    req_hs = 0; out_hs = 0;
    out_ready = 1'b0;
    send(LD_W, ST_NONE, 32'h8000_0020, 32'h0, 1'b1, 5'd11);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (mif.mem_req_valid !== 1'b1 || mif.mem_addr !== 32'h8000_0020 || mif.mem_wen !== 1'b0 || mif.mem_wmask !== 4'b0000) begin errors++; $display("FAIL bp_req_hold%0d: got v=%b %h %b %b want 1/80000020/0/0000", i, mif.mem_req_valid, mif.mem_addr, mif.mem_wen, mif.mem_wmask); end
      step();
    end
    mif.mem_req_ready = 1'b1;
    step();
    mif.mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (out_valid !== 1'b0 || mif.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_wait%0d: got ov=%b rv=%b want 0/0", i, out_valid, mif.mem_req_valid); end
      step();
    end
    mif.mem_rsp_valid = 1'b1; mif.mem_rdata = 32'h1357_9BDF;
    step();
    mif.mem_rsp_valid = 1'b0; mif.mem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      mif.mem_rsp_valid = (i == 0);
      vectors++; if (out_valid !== 1'b1 || m_regData !== 32'h1357_9BDF || m_regW !== 1'b1 || m_regAddr !== 5'd11) begin errors++; $display("FAIL bp_out_hold%0d: got ov=%b %h %b %0d want 1/13579bdf/1/11", i, out_valid, m_regData, m_regW, m_regAddr); end
      step();
    end
    mif.mem_rsp_valid = 1'b0;
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
    vectors++; if (req_hs !== 1 || out_hs !== 1) begin errors++; $display("FAIL bp_handshakes: got req=%0d out=%0d want 1/1", req_hs, out_hs); end
  endtask

  task automatic test_reset_mid();
    send(LD_W, ST_NONE, 32'h8000_0040, 32'h0, 1'b1, 5'd12);
    mif.mem_req_ready = 1'b1;
    step();
    mif.mem_req_ready = 1'b0;
    out_hs = 0;
    rst_n = 1'b0;
    mif.mem_rsp_valid = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
    step();
    rst_n = 1'b1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mif.mem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got ir=%b ov=%b rv=%b want 1/0/0", in_ready, out_valid, mif.mem_req_valid); end
    vectors++; if ({mif.mem_addr, mif.mem_wdata, mif.mem_wmask, mif.mem_wen, m_regW, m_regAddr, m_regData, m_misalign} !== 108'h0) begin errors++; $display("FAIL midrst_fields: got %h %h %h want zeros", mif.mem_addr, m_regData, m_regAddr); end
    step();
    mif.mem_rsp_valid = 1'b0; mif.mem_rdata = 32'h0;
    step();
    vectors++; if (out_valid !== 1'b0 || out_hs !== 0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_stray: got ov=%b hs=%0d ir=%b want 0/0/1", out_valid, out_hs, in_ready); end
  endtask

  initial begin
    in_valid = 1'b0; e_regW = 1'b0; e_regAddr = 5'd0; e_regData = 32'h0;
    e_load_inst = LD_NONE; e_store_mask = ST_NONE; e_store_data = 32'h0;
    out_ready = 1'b1;
    mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rdata = 32'h0;
    test_reset();
    test_lb();
    test_lh();
    test_sb();
    test_load_wins();
    test_misalign();
    test_alu();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly after the execute stage: it consumes the execute outputs (`e_regW`, `e_regAddr`, `e_regData`, `e_load_inst`, `e_store_mask`, `e_store_data`), issues at most one data-memory transaction per instruction over a valid/ready request and response interface, and produces the write-back triple. For a memory instruction, `e_regData` is the effective address. Non-memory instructions pass straight through to write-back with no memory access. One instruction is in flight at a time.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, register-file address width.
- `DATA_WIDTH`, 32, data/address width; only 32 is supported.

Ports (single clock; reset is synchronous and active-low):
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  execute output is valid.
- `in_ready`  out  1  LSU can accept an instruction.
- `e_regW`  in  1  write-back enable.
- `e_regAddr`  in  ADDR_WIDTH  destination register.
- `e_regData`  in  DATA_WIDTH  ALU result / effective address.
- `e_load_inst`  in  3  load kind: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as none.
- `e_store_mask`  in  4  unshifted lane mask: 0000 none, 0001 SB, 0011 SH, 1111 SW.
- `e_store_data`  in  DATA_WIDTH  unshifted store data (rs2).
- `mem_req_valid`  out  1  request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_addr`  out  DATA_WIDTH  word-aligned address (`{addr[31:2],2'b00}`).
- `mem_wen`  out  1  1 = store.
- `mem_wmask`  out  4  byte-lane mask, shifted by `addr[1:0]`.
- `mem_wdata`  out  DATA_WIDTH  store data, shifted by 8*`addr[1:0]`.
- `mem_rsp_valid`  in  1  response (read data or store ack); always accepted.
- `mem_rdata`  in  DATA_WIDTH  read word.
- `out_valid`  out  1  write-back result valid.
- `out_ready`  in  1  write-back accepts.
- `m_regW`  out  1  write-back enable.
- `m_regAddr`  out  ADDR_WIDTH  destination register.
- `m_regData`  out  DATA_WIDTH  write-back data.
- `m_misalign`  out  1  misaligned access flag, qualified by `out_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch all inputs.
  - Misaligned access (LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0): go to DONE with `m_misalign`=1, `m_regW`=0, and no memory request.
  - Otherwise, load or store (`e_load_inst`∈1..5 or `e_store_mask`≠0): go to REQ.
  - Otherwise: go to DONE with `m_regData`=`e_regData`.
- REQ:
  - `mem_req_valid`=1; request fields are held stable until `mem_req_ready`.
  - On `mem_req_ready`, go to WAIT.
- WAIT:
  - On `mem_rsp_valid`, go to DONE.
  - For a load, `m_regData` = extracted byte or halfword at `addr[1:0]`, sign- or zero-extended; LW passes the word through.
  - For a store, `m_regW` is forced to 0.
- DONE:
  - `out_valid`=1; outputs are held stable until `out_ready`, then go to IDLE.
- Load and store both nonzero on the same instruction: the load wins; the store mask is ignored.
- `mem_rsp_valid` is ignored outside WAIT; this discards stale responses after reset.
- A write to x0 is passed through unchanged; the register file suppresses it.

## Timing
- Reset values: state = IDLE, `in_ready`=1, and every other output = 0 (including `mem_addr`, `mem_wdata`, `mem_wmask` and `m_*`).
- Reset mid-operation in any state returns to IDLE on the next edge. The in-flight instruction is dropped and no `out_valid` is produced for it.
- Non-memory instruction: accepted at cycle T, `out_valid` at T+1.
- Memory instruction with zero-wait memory (ready in REQ, response the cycle after the request is accepted):
  - accepted at T, `mem_req_valid` at T+1, response at T+2, `out_valid` at T+3.
- Throughput: one instruction per (latency + 1) cycles; no acceptance in the cycle `out_valid` handshakes.
- All outputs are registered or decoded from state only; there is no combinational path from `mem_*` inputs to `mem_*` outputs.

## Structure
- Package `lsu_pkg`:
  - load-kind constants (LD_NONE, LD_B, LD_H, LD_W, LD_BU, LD_HU);
  - store-mask constants;
  - state enum.
- Sub-module `lsu_load_align`, purely combinational: inputs (`rdata`, `addr[1:0]`, `load_inst`), output the extended 32-bit value.
- Store shifting and the misalignment check stay inline.

## Test plan
- LB, addr 0x8000_0003, rdata 0x80FF_1234 -> `m_regData`=0xFFFF_FF80, `m_regW`=1, `mem_addr`=0x8000_0000.
- LHU, addr 0x8000_0002, rdata 0xBEEF_1234 -> `m_regData`=0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SB, addr 0x8000_0002, data 0x0000_00AB, mask 0001 -> `mem_wmask`=0100, `mem_wdata`=0x00AB_0000, `mem_wen`=1, `m_regW`=0.
- SW at addr 0x8000_0001 -> no `mem_req_valid` ever asserted, `out_valid` at T+1, `m_misalign`=1.
- Backpressure on LW:
  - `mem_req_ready` low for 3 cycles, response delayed 2 cycles, `out_ready` low for 2 cycles.
  - Required: request fields and `m_*` stay stable throughout; exactly one request and one `out_valid` handshake.
- ADD result 0x1234 to x5 -> `out_valid` at T+1 with `m_regData`=0x1234 and no memory activity.
- `rst_n` low in WAIT, then a stray `mem_rsp_valid` -> IDLE with all outputs 0, and the stray response produces no `out_valid`.
